// File: rtl/abp_sender_framer.sv
// Sender side of an Alternating Bit Protocol link. Accepts one 64-bit value,
// frames it as a 9-beat AXI-Stream byte packet (sequence byte followed by the
// value LSB first), then waits for a matching ACK. A timeout or a stale ACK
// causes a retransmission until the retry budget is spent.
//
// Handshakes: a value is accepted on a cycle where s_value_valid and
// s_value_ready are both high. A stream beat moves on a cycle where
// m_axis_tvalid and m_axis_tready are both high; while tvalid is high and
// tready is low, tdata and tlast hold their values. ack_valid is a one-cycle
// strobe with no back-pressure.
module abp_sender_framer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int TMR_WIDTH      = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_value_valid,
    output logic        s_value_ready,
    input  logic [63:0] s_value_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    input  logic        ack_valid,
    input  logic        ack_bit,
    output logic        seq_bit,
    output logic        busy,
    output logic [7:0]  retry_count,
    output logic        give_up
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    // Registered state and outputs
    state_t                 r_state;
    logic [63:0]            r_value;
    logic [3:0]             r_beat;
    logic [TMR_WIDTH-1:0]   r_timer;
    logic                   r_seq;
    logic                   r_busy;
    logic                   r_ready;
    logic [7:0]             r_retry;
    logic                   r_give_up;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [7:0]             r_tdata;

    // Next-state values
    state_t                 w_state;
    logic [63:0]            w_value;
    logic [3:0]             w_beat;
    logic [TMR_WIDTH-1:0]   w_timer;
    logic                   w_seq;
    logic                   w_busy;
    logic                   w_ready;
    logic [7:0]             w_retry;
    logic                   w_give_up;
    logic                   w_tvalid;
    logic                   w_tlast;
    logic [7:0]             w_tdata;

    // Decoded events
    logic                   w_xfer;
    logic                   w_timeout;
    logic                   w_ack_match;
    logic                   w_ack_stale;
    logic [7:0]             w_next_byte;

    assign w_xfer      = r_tvalid && m_axis_tready;
    assign w_timeout   = (r_timer == TMR_WIDTH'(TIMEOUT_CYCLES - 1));
    assign w_ack_match = ack_valid && (ack_bit == r_seq);
    assign w_ack_stale = ack_valid && (ack_bit != r_seq);
    // Payload byte for the beat after the current one: beat b+1 carries byte b
    assign w_next_byte = r_value[{r_beat[2:0], 3'b000} +: 8];

    // Next-state and registered-output decode for the protocol FSM
    always_comb begin
        w_state   = r_state;
        w_value   = r_value;
        w_beat    = r_beat;
        w_timer   = r_timer;
        w_seq     = r_seq;
        w_busy    = r_busy;
        w_ready   = r_ready;
        w_retry   = r_retry;
        w_give_up = 1'b0;
        w_tvalid  = r_tvalid;
        w_tlast   = r_tlast;
        w_tdata   = r_tdata;

        case (r_state)
            ST_IDLE: begin
                if (s_value_valid && r_ready) begin
                    w_value  = s_value_data;
                    w_retry  = 8'd0;
                    w_busy   = 1'b1;
                    w_ready  = 1'b0;
                    w_beat   = 4'd0;
                    w_tvalid = 1'b1;
                    w_tlast  = 1'b0;
                    w_tdata  = {7'b0, r_seq};
                    w_state  = ST_SEND;
                end
            end

            ST_SEND: begin
                if (w_xfer) begin
                    if (r_beat == 4'd8) begin
                        w_tvalid = 1'b0;
                        w_tlast  = 1'b0;
                        w_tdata  = 8'd0;
                        w_timer  = '0;
                        w_state  = ST_WAIT_ACK;
                    end else begin
                        w_beat  = r_beat + 4'd1;
                        w_tdata = w_next_byte;
                        w_tlast = (r_beat == 4'd7);
                    end
                end
            end

            ST_WAIT_ACK: begin
                w_timer = r_timer + TMR_WIDTH'(1);
                // A matching ACK takes priority over a simultaneous timeout
                if (w_ack_match) begin
                    w_seq   = ~r_seq;
                    w_busy  = 1'b0;
                    w_ready = 1'b1;
                    w_state = ST_IDLE;
                end else if (w_ack_stale || w_timeout) begin
                    if (r_retry < 8'(MAX_RETRIES)) begin
                        w_retry  = r_retry + 8'd1;
                        w_beat   = 4'd0;
                        w_tvalid = 1'b1;
                        w_tlast  = 1'b0;
                        w_tdata  = {7'b0, r_seq};
                        w_state  = ST_SEND;
                    end else begin
                        w_give_up = 1'b1;
                        w_busy    = 1'b0;
                        w_ready   = 1'b1;
                        w_state   = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset abandons any packet in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_value   <= 64'd0;
            r_beat    <= 4'd0;
            r_timer   <= '0;
            r_seq     <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_retry   <= 8'd0;
            r_give_up <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_value   <= w_value;
            r_beat    <= w_beat;
            r_timer   <= w_timer;
            r_seq     <= w_seq;
            r_busy    <= w_busy;
            r_ready   <= w_ready;
            r_retry   <= w_retry;
            r_give_up <= w_give_up;
            r_tvalid  <= w_tvalid;
            r_tlast   <= w_tlast;
            r_tdata   <= w_tdata;
        end
    end

    assign s_value_ready = r_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdata  = r_tdata;
    assign seq_bit       = r_seq;
    assign busy          = r_busy;
    assign retry_count   = r_retry;
    assign give_up       = r_give_up;

endmodule

// File: tb/tb_abp_sender_framer.sv
// Directed bench for abp_sender_framer. A packet-level model (queue of
// expected beats) is checked against the stream every cycle tvalid is high;
// directed checks pin sequence bit, retry count, timing and give-up.
module tb_abp_sender_framer;

  localparam int TMO  = 16;
  localparam int MAXR = 2;

  logic        aclk;
  logic        aresetn;
  logic        s_value_valid;
  logic        s_value_ready;
  logic [63:0] s_value_data;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        ack_valid;
  logic        ack_bit;
  logic        seq_bit;
  logic        busy;
  logic [7:0]  retry_count;
  logic        give_up;

  abp_sender_framer #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES(MAXR),
    .TMR_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_value_valid(s_value_valid),
    .s_value_ready(s_value_ready),
    .s_value_data(s_value_data),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .ack_valid(ack_valid),
    .ack_bit(ack_bit),
    .seq_bit(seq_bit),
    .busy(busy),
    .retry_count(retry_count),
    .give_up(give_up)
  );

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int edge_cnt = 0;
  initial forever begin
    @(posedge aclk);
    edge_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  // entry = {first_beat, tlast, data}
  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int pkt_count = 0;
  int xfer_cnt = 0;
  int first_edge = 0;
  int tlast_edge = 0;
  int pkt_span = 0;
  int last_gap = 0;
  int gu_cnt = 0;
  logic [7:0] first_data = 8'd0;
  logic prev_valid = 1'b0;
  logic stall_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of one packet: sequence byte then value bytes LSB first
  task automatic push_packet(input logic seq, input logic [63:0] v);
    logic [9:0] e;
    e = {1'b1, 1'b0, 7'b0, seq};
    exp_q.push_back(e);
    for (int b = 0; b < 8; b++) begin
      e = {1'b0, (b == 7), v[b*8 +: 8]};
      exp_q.push_back(e);
    end
  endtask

  // Compare process: stream checked on every cycle tvalid is high
  initial forever begin
    logic [9:0] e;
    @(negedge aclk);
    if (aresetn) begin
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h tlast %0b with no beat expected", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q[0];
          chk("stream_beat", {m_axis_tlast, m_axis_tdata}, e[8:0]);
          if (!prev_valid) last_gap = edge_cnt - tlast_edge;
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
            if (e[9]) begin
              first_edge = edge_cnt + 1;
              first_data = m_axis_tdata;
            end
            if (e[8]) begin
              tlast_edge = edge_cnt + 1;
              pkt_span = tlast_edge - first_edge;
              pkt_count++;
            end
          end
        end
      end
      if (give_up) gu_cnt++;
      prev_valid = m_axis_tvalid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // tready driver: always ready, or the 1-0-0-1 stall pattern
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = stall_mode ? pat[k % 4] : 1'b1;
      k++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_value(input logic [63:0] v, input logic seq);
    int n;
    n = 0;
    while (!s_value_ready && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("ready_before_accept", s_value_ready, 1'b1);
    s_value_valid = 1'b1;
    s_value_data  = v;
    push_packet(seq, v);
    @(posedge aclk);
    #1;
    s_value_valid = 1'b0;
    s_value_data  = {$urandom, $urandom};
    chk("accept_busy", busy, 1'b1);
    chk("accept_ready", s_value_ready, 1'b0);
  endtask

  task automatic wait_pkts(input int target);
    int n;
    n = 0;
    while (pkt_count < target && n < 300) begin
      @(posedge aclk);
      n++;
    end
    chk("pkt_wait", pkt_count, target);
    #1;
  endtask

  task automatic pulse_ack(input logic b);
    @(posedge aclk);
    #1;
    ack_valid = 1'b1;
    ack_bit   = b;
    @(posedge aclk);
    #1;
    ack_valid = 1'b0;
    ack_bit   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("idle_wait", busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int x0;
    aresetn = 1'b0;
    s_value_valid = 1'b0;
    s_value_data = 64'd0;
    ack_valid = 1'b0;
    ack_bit = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ready", s_value_ready, 1'b1);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 8'h00);
    chk("rst_seq", seq_bit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_retry", retry_count, 8'd0);
    chk("rst_give_up", give_up, 1'b0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // 1: basic packet, back-to-back, matching ACK 0
    send_value(64'h0807060504030201, 1'b0);
    wait_pkts(1);
    chk("t1_span", pkt_span, 8);
    chk("t1_beat0", first_data, 8'h00);
    pulse_ack(1'b0);
    chk("t1_seq", seq_bit, 1'b1);
    chk("t1_ready", s_value_ready, 1'b1);
    chk("t1_busy", busy, 1'b0);

    // 2: second value, ACK during SEND ignored, then ACK 1
    send_value(64'hAABBCCDDEEFF0011, 1'b1);
    pulse_ack(1'b1);
    wait_pkts(2);
    chk("t2_beat0", first_data, 8'h01);
    chk("t2_busy_after_ignored_ack", busy, 1'b1);
    chk("t2_seq_after_ignored_ack", seq_bit, 1'b1);
    chk("t2_retry", retry_count, 8'd0);
    pulse_ack(1'b1);
    chk("t2_seq", seq_bit, 1'b0);
    chk("t2_ready", s_value_ready, 1'b1);

    // 3: tready stalls 1-0-0-1
    stall_mode = 1'b1;
    x0 = xfer_cnt;
    send_value(64'h1122334455667788, 1'b0);
    wait_pkts(3);
    stall_mode = 1'b0;
    chk("t3_xfers", xfer_cnt - x0, 9);
    chk("t3_queue_empty", exp_q.size(), 0);
    pulse_ack(1'b0);
    chk("t3_seq", seq_bit, 1'b1);

    // 4: no ACK -> retransmit after TMO cycles
    send_value(64'hDEADBEEFCAFEF00D, 1'b1);
    push_packet(1'b1, 64'hDEADBEEFCAFEF00D);
    wait_pkts(4);
    chk("t4_retry_first", retry_count, 8'd0);
    wait_pkts(5);
    chk("t4_gap", last_gap, TMO);
    chk("t4_retry", retry_count, 8'd1);
    pulse_ack(1'b1);
    chk("t4_seq", seq_bit, 1'b0);
    chk("t4_busy", busy, 1'b0);

    // 5: stale ACK -> immediate retransmit
    send_value(64'h0123456789ABCDEF, 1'b0);
    wait_pkts(6);
    push_packet(1'b0, 64'h0123456789ABCDEF);
    pulse_ack(1'b1);
    wait_pkts(7);
    chk("t5_gap", last_gap, 2);
    chk("t5_retry", retry_count, 8'd1);
    pulse_ack(1'b0);
    chk("t5_seq", seq_bit, 1'b1);

    // 6: never ACK -> 1 + MAXR packets, then give_up
    gu_cnt = 0;
    send_value(64'hF0E1D2C3B4A59687, 1'b1);
    for (int r = 0; r < MAXR; r++) push_packet(1'b1, 64'hF0E1D2C3B4A59687);
    wait_pkts(7 + MAXR + 1);
    wait_idle();
    repeat (3) @(posedge aclk);
    #1;
    chk("t6_give_up_cycles", gu_cnt, 1);
    chk("t6_pkts", pkt_count, 10);
    chk("t6_seq", seq_bit, 1'b1);
    chk("t6_retry", retry_count, 8'd2);
    chk("t6_ready", s_value_ready, 1'b1);
    chk("t6_queue_empty", exp_q.size(), 0);

    // 7: reset mid-packet
    base = xfer_cnt;
    send_value(64'h5555AAAA3333CCCC, 1'b1);
    begin
      int n;
      n = 0;
      while (xfer_cnt < base + 3 && n < 100) begin
        @(posedge aclk);
        n++;
      end
    end
    #2;
    aresetn = 1'b0;
    #1;
    chk("t7_tvalid_async", m_axis_tvalid, 1'b0);
    chk("t7_seq_async", seq_bit, 1'b0);
    chk("t7_busy_async", busy, 1'b0);
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("t7_pkts", pkt_count, 10);
    chk("t7_ready", s_value_ready, 1'b1);
    chk("t7_tvalid", m_axis_tvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
